// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared register indices and bus word width for the GPIO pad
//               controller and its register interface.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

   // Register bus word width
   localparam int GPIO_WORD_W = 32;

   typedef logic [GPIO_WORD_W-1:0] gpio_word_t;
   typedef logic [2:0]             gpio_addr_t;

   // Register word indices
   localparam gpio_addr_t GPIO_DIR     = 3'd0;
   localparam gpio_addr_t GPIO_OUT     = 3'd1;
   localparam gpio_addr_t GPIO_IN      = 3'd2;
   localparam gpio_addr_t GPIO_RISE_EN = 3'd3;
   localparam gpio_addr_t GPIO_FALL_EN = 3'd4;
   localparam gpio_addr_t GPIO_PEND    = 3'd5;
   localparam gpio_addr_t GPIO_OUT_SET = 3'd6;
   localparam gpio_addr_t GPIO_OUT_CLR = 3'd7;

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_pad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl_if
// Description : Peripheral register bus (write/read strobes, word address,
//               write data, registered read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_pad_ctrl_if;
   import gpio_pkg::*;

   logic       we;
   logic       re;
   gpio_addr_t addr;
   gpio_word_t wdata;
   gpio_word_t rdata;

   // Bus initiator side
   modport master (
      output we,
      output re,
      output addr,
      output wdata,
      input  rdata
   );

   // Peripheral side
   modport slave (
      input  we,
      input  re,
      input  addr,
      input  wdata,
      output rdata
   );

endinterface : gpio_pad_ctrl_if
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync_edge
// Description : Multi-stage synchroniser for a bank of asynchronous inputs,
//               plus a previous-sample flop giving rise/fall pulses.
//               Usable for any bank of asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   // Shift the raw pin state through the synchroniser chain and keep the
   // previous synchronised sample for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            stage_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         stage_q[0] <= async_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
         prev_q <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = stage_q[SYNC_STAGES-1];
   assign rise_o = sync_o & ~prev_q;
   assign fall_o = ~sync_o & prev_q;

endmodule : gpio_sync_edge
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl
// Description : Register-programmed controller for NPIN bidirectional pads.
//               Owns pad enable (T), drive value (I) and synchronised
//               readback (O); raises a level interrupt from per-pin
//               rising/falling edge events.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl
   import gpio_pkg::*;
#(
   parameter int NPIN        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   gpio_pad_ctrl_if.slave        bus,
   output logic [NPIN-1:0]       pad_t,
   output logic [NPIN-1:0]       pad_i,
   input  logic [NPIN-1:0]       pad_o,
   output logic                  irq
);

   logic [NPIN-1:0] dir_q,     dir_d;
   logic [NPIN-1:0] out_q,     out_d;
   logic [NPIN-1:0] rise_en_q, rise_en_d;
   logic [NPIN-1:0] fall_en_q, fall_en_d;
   logic [NPIN-1:0] pend_q,    pend_d;
   gpio_word_t      rdata_q,   rdata_d;
   logic            irq_q;

   logic [NPIN-1:0] w_sync;
   logic [NPIN-1:0] w_rise;
   logic [NPIN-1:0] w_fall;
   logic [NPIN-1:0] w_wbits;
   logic [NPIN-1:0] w_clr;
   logic [NPIN-1:0] w_set;

   // Readback synchroniser and edge detector for the whole bank
   gpio_sync_edge #(
      .WIDTH       (NPIN),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .rstn    (rstn),
      .async_i (pad_o),
      .sync_o  (w_sync),
      .rise_o  (w_rise),
      .fall_o  (w_fall)
   );

   // Bits of the write word above NPIN have no register behind them
   generate
      if (NPIN < GPIO_WORD_W) begin : g_wdata_hi
         logic w_unused_wdata_hi;
         assign w_unused_wdata_hi = ^bus.wdata[GPIO_WORD_W-1:NPIN];
      end
   endgenerate

   assign w_wbits = bus.wdata[NPIN-1:0];

   // Register write decode, pending-bit update and read mux; the read mux
   // sees pre-write values so a simultaneous write and read returns old data
   always_comb begin
      dir_d     = dir_q;
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w_clr     = '0;

      if (bus.we) begin
         case (bus.addr)
            GPIO_DIR:     dir_d     = w_wbits;
            GPIO_OUT:     out_d     = w_wbits;
            GPIO_RISE_EN: rise_en_d = w_wbits;
            GPIO_FALL_EN: fall_en_d = w_wbits;
            GPIO_PEND:    w_clr     = w_wbits;
            GPIO_OUT_SET: out_d     = out_q | w_wbits;
            GPIO_OUT_CLR: out_d     = out_q & ~w_wbits;
            default:      ;  // IN is read-only
         endcase
      end

      // A new edge event wins over a same-cycle write-one-to-clear
      w_set  = (w_rise & rise_en_q) | (w_fall & fall_en_q);
      pend_d = (pend_q & ~w_clr) | w_set;

      rdata_d = rdata_q;
      if (bus.re) begin
         rdata_d = '0;
         case (bus.addr)
            GPIO_DIR:     rdata_d[NPIN-1:0] = dir_q;
            GPIO_OUT:     rdata_d[NPIN-1:0] = out_q;
            GPIO_IN:      rdata_d[NPIN-1:0] = w_sync;
            GPIO_RISE_EN: rdata_d[NPIN-1:0] = rise_en_q;
            GPIO_FALL_EN: rdata_d[NPIN-1:0] = fall_en_q;
            GPIO_PEND:    rdata_d[NPIN-1:0] = pend_q;
            default:      ;  // OUT_SET / OUT_CLR are write-only, read 0
         endcase
      end
   end

   // Register state, registered read data and registered interrupt
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dir_q     <= '0;
         out_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         out_q     <= out_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         rdata_q   <= rdata_d;
         irq_q     <= |pend_q;
      end
   end

   // Pads are driven straight from the registers: DIR=1 enables the driver
   assign pad_t     = ~dir_q;
   assign pad_i     = out_q;
   assign irq       = irq_q;
   assign bus.rdata = rdata_q;

endmodule : gpio_pad_ctrl
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pad_ctrl
// Description : Directed self-checking bench for gpio_pad_ctrl (NPIN=8,
//               SYNC_STAGES=2) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_ctrl;

   localparam int NPIN = 8;

   logic            clk;
   logic            rstn;
   logic [NPIN-1:0] pad_t;
   logic [NPIN-1:0] pad_i;
   logic [NPIN-1:0] pad_o;
   logic            irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;

   gpio_pad_ctrl_if bus ();

   gpio_pad_ctrl #(
      .NPIN        (NPIN),
      .SYNC_STAGES (2)
   ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus),
      .pad_t (pad_t),
      .pad_i (pad_i),
      .pad_o (pad_o),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      tick();
      bus.we    = 1'b0;
      bus.wdata = '0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
      bus.re   = 1'b1;
      bus.addr = a;
      tick();
      bus.re   = 1'b0;
      d        = bus.rdata;
   endtask

   // Hard bound on total run time
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rstn      = 1'b0;
      pad_o     = 8'hFF;
      bus.we    = 1'b0;
      bus.re    = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;

      // ---- Reset with pins held high ----
      tick(); tick(); tick();
      check("rst_pad_t", {24'h0, pad_t}, 32'h0000_00FF);
      check("rst_pad_i", {24'h0, pad_i}, 32'h0000_0000);
      check("rst_irq",   {31'h0, irq},   32'h0);
      check("rst_rdata", bus.rdata,      32'h0);

      rstn = 1'b1;
      tick(); tick(); tick();
      reg_read(3'd2, rd);
      check("in_after_reset", rd, 32'h0000_00FF);
      reg_read(3'd5, rd);
      check("pend_no_rise_latch", rd, 32'h0);

      // ---- Direction and drive ----
      reg_write(3'd0, 32'h0000_000F);
      check("dir_pad_t", {24'h0, pad_t}, 32'h0000_00F0);
      reg_write(3'd1, 32'hFFFF_FFA5);
      check("out_pad_i", {24'h0, pad_i}, 32'h0000_00A5);
      reg_read(3'd0, rd);
      check("dir_read", rd, 32'h0000_000F);
      reg_read(3'd1, rd);
      check("out_read_upper0", rd, 32'h0000_00A5);

      // ---- OUT_SET / OUT_CLR ----
      reg_write(3'd6, 32'h0000_000A);
      reg_write(3'd7, 32'h0000_0020);
      reg_read(3'd1, rd);
      check("out_set_clr", rd, 32'h0000_008F);
      check("out_set_clr_pad_i", {24'h0, pad_i}, 32'h0000_008F);
      reg_read(3'd6, rd);
      check("out_set_reads0", rd, 32'h0);
      reg_read(3'd7, rd);
      check("out_clr_reads0", rd, 32'h0);

      // ---- Simultaneous write and read returns the pre-write value ----
      bus.we    = 1'b1;
      bus.re    = 1'b1;
      bus.addr  = 3'd1;
      bus.wdata = 32'h0000_0033;
      tick();
      bus.we    = 1'b0;
      bus.re    = 1'b0;
      check("wr_rd_old", bus.rdata, 32'h0000_008F);
      reg_read(3'd1, rd);
      check("wr_rd_new", rd, 32'h0000_0033);

      // ---- Rising-edge interrupt ----
      pad_o = 8'h00;
      tick(); tick(); tick(); tick();
      reg_write(3'd3, 32'h0000_0001);
      pad_o = 8'h01;                      // change before edge c+1
      tick(); tick();                     // sync now high, PEND sets on next edge
      bus.re   = 1'b1;
      bus.addr = 3'd5;
      tick();                             // edge c+3: PEND loads
      check("pend_before_set", bus.rdata, 32'h0);
      check("irq_c3", {31'h0, irq}, 32'h0);
      tick();                             // edge c+4
      bus.re = 1'b0;
      check("pend_c3", bus.rdata, 32'h0000_0001);
      check("irq_c4", {31'h0, irq}, 32'h1);
      reg_write(3'd5, 32'h0000_0001);
      check("irq_hold_after_w1c", {31'h0, irq}, 32'h1);
      tick();
      check("irq_clear", {31'h0, irq}, 32'h0);

      // ---- Set beats simultaneous W1C ----
      pad_o = 8'h03;
      tick(); tick(); tick(); tick();
      reg_read(3'd5, rd);
      check("pend_no_rise1", rd, 32'h0);
      reg_write(3'd4, 32'h0000_0002);
      pad_o = 8'h01;                      // pin 1 falls
      tick(); tick();
      reg_write(3'd5, 32'h0000_0002);     // W1C on the edge the fall sets PEND[1]
      reg_read(3'd5, rd);
      check("set_wins_w1c", rd, 32'h0000_0002);
      check("irq_set_wins", {31'h0, irq}, 32'h1);
      reg_write(3'd5, 32'h0000_0002);
      reg_read(3'd5, rd);
      check("pend_cleared", rd, 32'h0);

      // ---- Asynchronous reset mid-operation ----
      reg_write(3'd0, 32'h0000_00FF);
      reg_write(3'd1, 32'h0000_00FF);
      pad_o = 8'h00;
      tick(); tick(); tick(); tick();
      pad_o = 8'h01;
      tick(); tick(); tick(); tick();
      check("pre_rst_irq", {31'h0, irq}, 32'h1);
      check("pre_rst_pad_t", {24'h0, pad_t}, 32'h0);
      reg_read(3'd0, rd);
      check("pre_rst_dir", rd, 32'h0000_00FF);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_pad_t", {24'h0, pad_t}, 32'h0000_00FF);
      check("arst_pad_i", {24'h0, pad_i}, 32'h0);
      check("arst_irq",   {31'h0, irq},   32'h0);
      check("arst_rdata", bus.rdata,      32'h0);
      #4;
      rstn = 1'b1;
      tick();
      reg_read(3'd0, rd);
      check("post_rst_dir", rd, 32'h0);
      reg_read(3'd1, rd);
      check("post_rst_out", rd, 32'h0);
      reg_read(3'd3, rd);
      check("post_rst_rise_en", rd, 32'h0);
      reg_read(3'd4, rd);
      check("post_rst_fall_en", rd, 32'h0);
      reg_read(3'd5, rd);
      check("post_rst_pend", rd, 32'h0);
      check("post_rst_irq", {31'h0, irq}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_gpio_pad_ctrl
`default_nettype wire

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Register-programmed controller for a bank of N bidirectional pads.
- Each pad is instantiated at top level as the team's tri-state iopad primitive.
- The block owns each pad's enable (T), drive value (I) and synchronised readback (O).
- Also generates per-pin edge interrupts from readback; sits on the peripheral register bus beside the other minion peripherals.

Parameters:
- NPIN, 8, number of pads controlled (1..32).
- SYNC_STAGES, 2, readback synchroniser depth (2..3).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- we  input  1  register write strobe, one cycle per write.
- re  input  1  register read strobe, one cycle per read.
- addr  input  3  register word index.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- pad_t  output  NPIN  to iopad T; 1 = high-Z/input, 0 = drive.
- pad_i  output  NPIN  to iopad I; value driven when pad_t=0.
- pad_o  input  NPIN  from iopad O; asynchronous pin state.
- irq  output  1  level interrupt, OR of enabled pending bits.

Behaviour:
- Decided interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values:
  - DIR=0, so every pad is input and pad_t is all-ones.
  - OUT=0, so pad_i is all zeros.
  - RISE_EN, FALL_EN, PEND all 0; irq=0; rdata=0.
  - Synchroniser and previous-sample flops all 0.
- Register map (addr, bits [NPIN-1:0], upper bits read 0, writes to them ignored):
  - 0 DIR, rw, 1 = output.
  - 1 OUT, rw.
  - 2 IN, ro: synchronised pin state.
  - 3 RISE_EN, rw.
  - 4 FALL_EN, rw.
  - 5 PEND, rw1c.
  - 6 OUT_SET, wo: OUT |= wdata.
  - 7 OUT_CLR, wo: OUT &= ~wdata.
- Write-only registers read 0. Reads and writes to addr 2 (writes) are ignored.
- Writes take effect at the clk edge where we=1.
  - pad_t = ~DIR and pad_i = OUT, driven directly from registers.
  - A new value is therefore visible at the pads one cycle after the write edge.
- Read latency:
  - rdata is loaded at the edge where re=1 and is valid the following cycle.
  - rdata holds its value until the next re.
  - we and re asserted together: write is performed, and the read returns the pre-write value.
- Readback path:
  - pad_o passes through SYNC_STAGES flops to give sync.
  - prev <= sync every cycle.
  - IN = sync, so IN latency from pin change is SYNC_STAGES cycles.
- Edge detection, per pin:
  - rise = sync & ~prev; fall = ~sync & prev.
  - set = (rise & RISE_EN) | (fall & FALL_EN).
  - PEND <= (PEND & ~clr) | set, where clr = wdata on a PEND write, otherwise 0.
  - Set wins over a simultaneous W1C of the same bit.
  - Output pins are detected too: OUT toggles loop back through the pad.
- irq = |PEND, registered from PEND. irq asserts 1 cycle after the PEND bit sets and deasserts 1 cycle after the clear.
- Pin held high through reset:
  - Produces a rise event SYNC_STAGES+1 cycles after reset release.
  - It is not latched because RISE_EN=0 at that time.
- Direction change (DIR 1→0) releases the pad next cycle. No guard cycles; board pull-ups are the system's responsibility.
- Reset mid-operation (rstn low at any time) asynchronously returns everything to reset values, including releasing all pads. No pending write survives.
- Out-of-range addresses do not occur (3-bit address, all 8 decoded).

Decomposition:
- Shared package gpio_pkg holds:
  - register index constants (GPIO_DIR..GPIO_OUT_CLR);
  - the register word width constant (32).
- Sub-module gpio_sync_edge: per-bank synchroniser plus prev flop, outputs sync, rise and fall.
  - Parameterised by width and SYNC_STAGES.
  - Also reusable for the UART and SD card-detect inputs.

Test Plan:
- Reset: hold rstn=0 with pad_o=8'hFF -> pad_t=8'hFF, pad_i=0, irq=0. Read addr 2 after SYNC_STAGES+1 cycles -> rdata=32'h000000FF.
- Direction/drive: write DIR=8'h0F, then OUT=8'hA5 -> pad_t=8'hF0 one cycle after the DIR write, pad_i=8'hA5 one cycle after the OUT write.
- Set/clear: write OUT_SET=8'h0A, then OUT_CLR=8'h20 -> OUT reads 8'h8F. Reads of addr 6 and 7 return 0.
- Rising IRQ: RISE_EN=8'h01; pad_o[0] 0→1 at cycle c -> PEND=8'h01 at c+3, irq=1 at c+4. W1C PEND 8'h01 -> irq=0 one cycle later.
- Simultaneous set/clear: FALL_EN=8'h02; pad_o[1] falls so its set lands on the same edge as W1C 8'h02 -> PEND[1] remains 1.
- Async reset mid-op: DIR=8'hFF, OUT=8'hFF, PEND nonzero; pulse rstn low for half a cycle -> pad_t=8'hFF, irq=0, and all registers read 0 afterwards.
